// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-port, synchronous-read word memory between the CPU
//   instruction-fetch port (read-only) and the data port (read/write).
//   One access is in flight at a time; each grant walks
//   IDLE -> ISSUE -> CAPTURE -> ACK, so a request seen in IDLE is acknowledged
//   three cycles later and accesses issue at most once every four cycles.
//
//   Configuration macro: ARB_RR_EN
//     undefined : fixed priority, data port beats fetch on a tie
//     defined   : round-robin on a tie, using a 1-bit last-owner register
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_req/i_addr               fetch request (held until i_ack) and word address
//   i_ack/i_rdata              fetch completion pulse and fetched word (held)
//   d_read_en/d_write_en       data read / write requests (held until d_ack)
//   d_addr/d_write_data        data word address and write data
//   d_ack/d_rdata/d_err        data completion pulse, read word (held), range error
//   mem_en/mem_we              memory access strobe and write enable
//   mem_addr/mem_wdata         memory word address and write data
//   mem_rdata                  memory read data, valid the cycle after mem_en
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_read_en,
  input  logic              d_write_en,
  input  logic [31:0]       d_addr,
  input  logic [DATA_W-1:0] d_write_data,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_ACK     = 2'd3
  } state_t;

  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic                we_q, we_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  logic                i_ack_q, i_ack_d;
  logic                d_ack_q, d_ack_d;
  logic                d_err_q, d_err_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

  logic                d_pend_s;
  logic                pend_s;
  logic                d_oor_s;
  logic                grant_data_s;
  logic                unused_s;

  assign d_pend_s = d_read_en | d_write_en;
  assign pend_s   = i_req | d_pend_s;
  // Any set bit above the memory's address range makes a data access illegal.
  assign d_oor_s  = |d_addr[31:ADDR_W];
  // Fetch addresses simply wrap modulo the memory depth.
  assign unused_s = ^i_addr[31:ADDR_W];

`ifdef ARB_RR_EN
  logic last_owner_q, last_owner_d;

  // On a tie the port that was not granted last wins.
  assign grant_data_s = d_pend_s & (~i_req | (last_owner_q == OWN_FETCH));

  // Last-owner register for round-robin tie breaking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_owner_q <= OWN_FETCH;
    end else begin
      last_owner_q <= last_owner_d;
    end
  end

  // Last owner updates at every grant.
  always_comb begin
    last_owner_d = last_owner_q;
    if ((state_q == S_IDLE) && pend_s) begin
      last_owner_d = grant_data_s;
    end else begin
      last_owner_d = last_owner_q;
    end
  end
`else
  assign grant_data_s = d_pend_s;
`endif

  // State register and latched transaction context.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      owner_q <= OWN_FETCH;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= {ADDR_W{1'b0}};
      wdata_q <= {DATA_W{1'b0}};
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Next-state logic; the grant context is latched when leaving IDLE.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (pend_s) begin
          state_d = S_ISSUE;
          owner_d = grant_data_s;
          // Read and write together is treated as a write.
          we_d    = grant_data_s & d_write_en;
          err_d   = grant_data_s & d_oor_s;
          if (grant_data_s) begin
            addr_d = d_addr[ADDR_W-1:0];
          end else begin
            addr_d = i_addr[ADDR_W-1:0];
          end
          if (grant_data_s && d_write_en) begin
            wdata_d = d_write_data;
          end else begin
            wdata_d = wdata_q;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE:   state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_ACK;
      S_ACK:     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output next values, decoded from the upcoming state so outputs stay registered.
  always_comb begin
    mem_en_d  = (state_d == S_ISSUE) & ~err_d;
    mem_we_d  = (state_d == S_ISSUE) & ~err_d & we_d;
    i_ack_d   = (state_d == S_ACK) & (owner_q == OWN_FETCH);
    d_ack_d   = (state_d == S_ACK) & (owner_q == OWN_DATA);
    d_err_d   = (state_d == S_ACK) & (owner_q == OWN_DATA) & err_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    if (state_q == S_CAPTURE) begin
      if (owner_q == OWN_FETCH) begin
        i_rdata_d = mem_rdata;
      end else if (!we_q) begin
        // A suppressed out-of-range read returns zero.
        d_rdata_d = err_q ? {DATA_W{1'b0}} : mem_rdata;
      end else begin
        d_rdata_d = d_rdata_q;
      end
    end else begin
      i_rdata_d = i_rdata_q;
      d_rdata_d = d_rdata_q;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      d_err_q   <= 1'b0;
      i_rdata_q <= {DATA_W{1'b0}};
      d_rdata_q <= {DATA_W{1'b0}};
    end else begin
      mem_en_q  <= mem_en_d;
      mem_we_q  <= mem_we_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
      d_err_q   <= d_err_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign i_ack     = i_ack_q;
  assign d_ack     = d_ack_q;
  assign d_err     = d_err_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//   Drives mem_arbiter against a behavioural memory, predicts every
//   acknowledgement from a word-array reference model and checks acks through
//   a scoreboard queue popped by an independent monitor.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i_req = 1'b0;
  logic [31:0]       i_addr = 32'd0;
  logic              i_ack;
  logic [DATA_W-1:0] i_rdata;
  logic              d_read_en = 1'b0;
  logic              d_write_en = 1'b0;
  logic [31:0]       d_addr = 32'd0;
  logic [DATA_W-1:0] d_write_data = 32'd0;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic              d_err;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_read_en(d_read_en), .d_write_en(d_write_en), .d_addr(d_addr),
    .d_write_data(d_write_data), .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural single-port synchronous-read memory.
  logic [31:0] mem_arr [0:1023];
  logic        init_we = 1'b0;
  logic [9:0]  init_addr = 10'd0;
  logic [31:0] init_data = 32'd0;

  always @(posedge clk) begin
    if (init_we) mem_arr[init_addr] <= init_data;
    else if (mem_en && mem_we) mem_arr[mem_addr] <= mem_wdata;
    if (mem_en) mem_rdata <= mem_arr[mem_addr];
  end

  // Reference model state.
  typedef struct packed {
    logic        port;   // 1 = data, 0 = fetch
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [0:1023];
  logic        last_port = 1'b0;
  logic [31:0] i_last = 32'd0;
  logic [31:0] d_last = 32'd0;
  int          checks = 0;
  int          passes = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h required %0h", name, got, exp);
  endtask

  function automatic bit is_oor(input int kind, input logic [31:0] addr);
    return (kind != 0) && (addr[31:10] != 22'd0);
  endfunction

  // kind: 0 fetch, 1 data read, 2 data write, 3 read+write (acts as write)
  task automatic model_push(input int kind, input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    bit   oor = is_oor(kind, addr);
    e.port = (kind != 0);
    e.err  = oor;
    if (kind == 0) begin
      e.rdata = ref_mem[addr[9:0]];
      i_last  = e.rdata;
    end else if (kind == 1) begin
      e.rdata = oor ? 32'd0 : ref_mem[addr[9:0]];
      d_last  = e.rdata;
    end else begin
      if (!oor) ref_mem[addr[9:0]] = wdata;
      e.rdata = d_last;
    end
    last_port = e.port;
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    last_port = 1'b0;
    i_last    = 32'd0;
    d_last    = 32'd0;
  endtask

  task automatic drop_all();
    i_req      = 1'b0;
    d_read_en  = 1'b0;
    d_write_en = 1'b0;
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, 64'({i_ack, d_ack, d_err, mem_en, mem_we} | (|i_rdata) | (|d_rdata)
                  | (|mem_addr) | (|mem_wdata)), 64'd0);
  endtask

  // Monitor: every ack pops the scoreboard and is compared.
  exp_t mon_e;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && (i_ack || d_ack)) begin
        chk("single_ack", 64'(i_ack & d_ack), 64'd0);
        chk("ack_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("ack_response", {29'd0, d_ack, d_err, (d_ack ? d_rdata : i_rdata)},
              {29'd0, mon_e.port, mon_e.err, mon_e.rdata});
        end
      end
    end
  end

  task automatic reset_and_init();
    rst_n   = 1'b0;
    drop_all();
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      init_we   = 1'b1;
      init_addr = i[9:0];
      init_data = (i == 5) ? 32'h2402_0001 : $urandom;
      ref_mem[i] = init_data;
    end
    @(negedge clk);
    init_we = 1'b0;
    model_reset();
    chk_all_zero("reset_state");
    rst_n = 1'b1;
  endtask

  // One transaction with latency and memory-strobe checks.
  task automatic do_txn(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                        input bit early);
    int          cnt = 0, ack_cyc = -1, en_cnt = 0, en_cyc = -1;
    logic        we_seen = 1'b0;
    logic [9:0]  addr_seen = 10'd0;
    logic [31:0] wd_seen = 32'd0;
    bit          oor = is_oor(kind, addr);
    bit          exp_we = !oor && (kind >= 2);
    model_push(kind, addr, wdata);
    @(negedge clk);
    case (kind)
      0: begin i_req = 1'b1; i_addr = addr; end
      1: begin d_read_en = 1'b1; d_addr = addr; end
      2: begin d_write_en = 1'b1; d_addr = addr; d_write_data = wdata; end
      default: begin d_read_en = 1'b1; d_write_en = 1'b1; d_addr = addr; d_write_data = wdata; end
    endcase
    while (ack_cyc < 0 && cnt < 12) begin
      @(negedge clk);
      cnt++;
      if (mem_en) begin
        en_cnt++;
        if (en_cyc < 0) en_cyc = cnt;
        addr_seen = mem_addr;
        if (mem_we) begin we_seen = 1'b1; wd_seen = mem_wdata; end
      end
      if (i_ack || d_ack) ack_cyc = cnt;
      if (early && cnt == 1) drop_all();
    end
    drop_all();
    chk("ack_latency", 64'(ack_cyc), 64'(3));
    chk("mem_issue", {5'd0, 8'(en_cnt), 8'(en_cyc), we_seen, addr_seen, wd_seen},
        {5'd0, 8'(oor ? 0 : 1), 8'(oor ? -1 : 1), 1'(exp_we),
         (oor ? 10'd0 : addr[9:0]), (exp_we ? wdata : 32'd0)});
  endtask

  // Both ports requesting together and held for four grants.
  task automatic tie_test();
    int          acks = 0, cyc = 0;
    logic [31:0] ai = 32'hABC0_0011;
    logic [31:0] ad = 32'h0000_0016;
    for (int g = 0; g < 4; g++) begin
`ifdef ARB_RR_EN
      if (last_port == 1'b0) model_push(1, ad, 32'd0);
      else model_push(0, ai, 32'd0);
`else
      model_push(1, ad, 32'd0);
`endif
    end
    @(negedge clk);
    i_req = 1'b1; i_addr = ai; d_read_en = 1'b1; d_addr = ad;
    while (acks < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (i_ack || d_ack) acks++;
    end
    drop_all();
    chk("tie_grants", 64'(acks), 64'(4));
  endtask

  // Reset asserted while a read is in its capture cycle.
  task automatic reset_mid_capture();
    @(negedge clk);
    d_read_en = 1'b1; d_addr = 32'd7;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk_all_zero("abort_outputs");
    drop_all();
    repeat (2) @(negedge clk);
    chk_all_zero("abort_held");
    model_reset();
    rst_n = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int          kind;
    logic [31:0] hi, lo, a;
    reset_and_init();
    do_txn(0, 32'd5, 32'd0, 1'b0);
    do_txn(2, 32'd12, 32'hDEAD_BEEF, 1'b0);
    do_txn(1, 32'd12, 32'd0, 1'b0);
    do_txn(3, 32'd3, 32'h1, 1'b0);
    do_txn(1, 32'd3, 32'd0, 1'b0);
    do_txn(2, 32'h0000_0400, 32'hCAFE_F00D, 1'b0);
    do_txn(1, 32'd0, 32'd0, 1'b0);
    do_txn(1, 32'h0001_0007, 32'd0, 1'b0);
    do_txn(1, 32'd9, 32'd0, 1'b1);
    do_txn(0, 32'hFFFF_FC02, 32'd0, 1'b1);
    reset_and_init();
    tie_test();
    do_txn(1, 32'd4, 32'd0, 1'b0);
    reset_mid_capture();
    do_txn(0, 32'd5, 32'd0, 1'b0);
    for (int n = 0; n < 60; n++) begin
      kind = int'($urandom_range(0, 3));
      lo   = $urandom_range(0, 31);
      if (kind != 0 && $urandom_range(0, 7) == 0) hi = $urandom_range(1, 32'h003F_FFFF);
      else if (kind == 0) hi = $urandom_range(0, 32'h003F_FFFF);
      else hi = 32'd0;
      a = (hi << 10) | lo;
      do_txn(kind, a, $urandom, ($urandom_range(0, 7) == 0));
    end
    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
